// File: rtl/alu_pkg.sv
// alu_pkg: operation group/op encodings and FSM states shared by the ALU blocks
package alu_pkg;
    localparam logic [1:0] GRP_LOGIC = 2'd0, GRP_ARIT = 2'd1, GRP_EXT = 2'd2;
    localparam logic [1:0] OP_AND = 2'd0, OP_OR = 2'd1, OP_XOR = 2'd2, OP_NOT = 2'd3;
    localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_NEGA = 2'd2, OP_NEGB = 2'd3;
    localparam logic [1:0] OP_MUL = 2'd0, OP_ADC = 2'd1, OP_SHL = 2'd2, OP_ASR = 2'd3;
    typedef enum logic {IDLE, BUSY} state_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational single-cycle datapath for every op except MUL
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             arit,
    input  logic             ext,
    input  logic             c_in,
    output logic [WIDTH-1:0] result,
    output logic             z,
    output logic             c,
    output logic             s,
    output logic             v
);
    localparam int M = WIDTH - 1;
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    logic [1:0]       w_grp;
    logic [WIDTH-1:0] w_x, w_y, w_logic;
    logic             w_ci, w_vadd, w_vsub;
    logic [WIDTH:0]   w_sum;
    // One shared adder serves add, sub, both negates and ADC
    always_comb begin
        w_grp = ext ? GRP_EXT : (arit ? GRP_ARIT : GRP_LOGIC);
        w_x = (w_grp == GRP_ARIT && op == OP_NEGA) ? ~a : (w_grp == GRP_ARIT && op == OP_NEGB) ? '0 : a;
        w_y = (w_grp != GRP_ARIT || op == OP_ADD) ? b : (op == OP_NEGA) ? '0 : ~b;
        w_ci = (w_grp == GRP_ARIT) ? (op != OP_ADD) : c_in;
        w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_ci};
        w_logic = (op == OP_AND) ? a & b : (op == OP_OR) ? a | b : (op == OP_XOR) ? a ^ b : ~a;
        w_vadd = (a[M] == b[M]) && (w_sum[M] != a[M]);
        w_vsub = (a[M] != b[M]) && (w_sum[M] != a[M]);
        result = w_sum[M:0];
        c = w_sum[WIDTH];
        v = 1'b0;
        case (w_grp)
            GRP_LOGIC: begin
                result = w_logic;
                c = 1'b0;
            end
            GRP_ARIT: v = (op == OP_ADD) ? w_vadd : (op == OP_SUB) ? w_vsub : (op == OP_NEGA) ? (a == MIN) : (b == MIN);
            default: case (op)
                OP_ADC: v = w_vadd;
                OP_SHL: begin
                    result = {a[M-1:0], 1'b0};
                    c = a[M];
                    v = a[M] ^ a[M-1];
                end
                OP_ASR: begin
                    result = {a[M], a[M:1]};
                    c = a[0];
                end
                default: begin
                    result = '0;
                    c = 1'b0;
                end
            endcase
        endcase
        z = (result == '0);
        s = result[M];
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready input and an iterative shift-add multiplier
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             arit,
    input  logic             ext,
    output logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] r_hi,
    output logic             z,
    output logic             c,
    output logic             s,
    output logic             v,
    output logic             out_valid
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_mcand, r_acc, w_acc_nxt;
    logic [WIDTH-1:0]   r_mplier, r_res_lo, r_res_hi, w_core_r;
    logic               r_z, r_c, r_s, r_v, r_out_valid;
    logic               w_core_z, w_core_c, w_core_s, w_core_v;
    logic               w_accept, w_mul_start, w_mul_done;
    alu_core #(.WIDTH(WIDTH)) u_core (
        .a(a), .b(b), .op(op), .arit(arit), .ext(ext), .c_in(r_c),
        .result(w_core_r), .z(w_core_z), .c(w_core_c), .s(w_core_s), .v(w_core_v)
    );
    always_comb begin
        in_ready = (r_state == IDLE) && !reset;
        w_accept = in_valid && in_ready;
        w_mul_start = w_accept && ext && (op == OP_MUL);
        w_mul_done = (r_state == BUSY) && (r_cnt == LAST);
        w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
        w_state_nxt = (r_state == IDLE) ? (w_mul_start ? BUSY : IDLE) : (w_mul_done ? IDLE : BUSY);
    end
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
            r_mcand <= '0;
            r_mplier <= '0;
            r_acc <= '0;
            r_res_lo <= '0;
            r_res_hi <= '0;
            {r_z, r_c, r_s, r_v, r_out_valid} <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_accept && !w_mul_start) begin
                r_res_lo <= w_core_r;
                r_res_hi <= '0;
                {r_z, r_c, r_s, r_v} <= {w_core_z, w_core_c, w_core_s, w_core_v};
                r_out_valid <= 1'b1;
            end
            if (w_mul_start) begin
                r_mcand <= {{WIDTH{1'b0}}, a};
                r_mplier <= b;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == BUSY) begin
                r_acc <= w_acc_nxt;
                r_mcand <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt <= r_cnt + 1'b1;
                if (w_mul_done) begin
                    r_res_lo <= w_acc_nxt[WIDTH-1:0];
                    r_res_hi <= w_acc_nxt[2*WIDTH-1:WIDTH];
                    r_z <= (w_acc_nxt == '0);
                    r_c <= |w_acc_nxt[2*WIDTH-1:WIDTH];
                    r_s <= w_acc_nxt[2*WIDTH-1];
                    r_v <= 1'b0;
                    r_out_valid <= 1'b1;
                end
            end
        end
    end
    assign r = r_res_lo;
    assign r_hi = r_res_hi;
    assign {z, c, s, v, out_valid} = {r_z, r_c, r_s, r_v, r_out_valid};
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vector table, exhaustive ext=0 sweep and multi-cycle MUL/reset sequences
module tb_alu_seq;
    localparam int W = 4;
    logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, arit = 1'b0, ext = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic [1:0] op = '0;
    logic in_ready, z, c, s, v, out_valid;
    logic [W-1:0] r, r_hi;
    int n_chk = 0, n_fail = 0;
    typedef struct {
        logic       ext;
        logic       arit;
        logic [1:0] op;
        logic [3:0] a, b, r;
        logic       z, c, s, v;
    } vec_t;
    vec_t vec[17];
    always #5 clk = ~clk;
    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .arit(arit), .ext(ext),
        .r(r), .r_hi(r_hi), .z(z), .c(c), .s(s), .v(v), .out_valid(out_valid)
    );
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic drive(input logic e, input logic ar, input logic [1:0] o, input logic [3:0] xa, input logic [3:0] xb);
        @(negedge clk);
        ext = e; arit = ar; op = o; a = xa; b = xb; in_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask
    // Reference for ext=0 using integer arithmetic; returns {r, z, c, s, v}
    function automatic logic [7:0] model(input logic ar, input int o, input int xa, input int xb);
        int res, t, cc, vv, sa, sb;
        sa = (xa > 7) ? xa - 16 : xa;
        sb = (xb > 7) ? xb - 16 : xb;
        cc = 0; vv = 0; res = 0;
        if (!ar) begin
            res = (o == 0) ? (xa & xb) : (o == 1) ? (xa | xb) : (o == 2) ? (xa ^ xb) : (~xa & 15);
        end else if (o == 0) begin
            t = xa + xb; res = t & 15; cc = (t >> 4) & 1; vv = int'((sa + sb) > 7 || (sa + sb) < -8);
        end else if (o == 1) begin
            t = xa + 16 - xb; res = t & 15; cc = (t >> 4) & 1; vv = int'((sa - sb) > 7 || (sa - sb) < -8);
        end else if (o == 2) begin
            t = (~xa & 15) + 1; res = t & 15; cc = (t >> 4) & 1; vv = int'(xa == 8);
        end else begin
            t = (~xb & 15) + 1; res = t & 15; cc = (t >> 4) & 1; vv = int'(xb == 8);
        end
        return {res[3:0], res == 0, cc[0], res[3], vv[0]};
    endfunction
    initial begin
        int k, pulses;
        logic [7:0] e;
        vec[0]  = '{1'b0, 1'b1, 2'd0, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[1]  = '{1'b0, 1'b1, 2'd1, 4'b0101, 4'b0101, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[2]  = '{1'b0, 1'b1, 2'd2, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[3]  = '{1'b0, 1'b1, 2'd2, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[4]  = '{1'b0, 1'b0, 2'd0, 4'b1100, 4'b1010, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[5]  = '{1'b0, 1'b0, 2'd1, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0};
        vec[6]  = '{1'b0, 1'b0, 2'd2, 4'b1010, 4'b0110, 4'b1100, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[7]  = '{1'b0, 1'b0, 2'd3, 4'b0101, 4'b0000, 4'b1010, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[8]  = '{1'b0, 1'b1, 2'd3, 4'b0000, 4'b0011, 4'b1101, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[9]  = '{1'b1, 1'b0, 2'd2, 4'b1100, 4'b0000, 4'b1000, 1'b0, 1'b1, 1'b1, 1'b0};
        vec[10] = '{1'b1, 1'b0, 2'd3, 4'b1001, 4'b0000, 4'b1100, 1'b0, 1'b1, 1'b1, 1'b0};
        vec[11] = '{1'b1, 1'b0, 2'd2, 4'b0100, 4'b0000, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1};
        vec[12] = '{1'b1, 1'b0, 2'd3, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vec[13] = '{1'b0, 1'b1, 2'd1, 4'b0011, 4'b0101, 4'b1110, 1'b0, 1'b0, 1'b1, 1'b0};
        vec[14] = '{1'b0, 1'b1, 2'd1, 4'b1000, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b1};
        vec[15] = '{1'b1, 1'b1, 2'd1, 4'b0010, 4'b0011, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0};
        vec[16] = '{1'b1, 1'b0, 2'd1, 4'b0111, 4'b0001, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b1};
        repeat (3) @(posedge clk);
        #1;
        chk("ready_in_reset", in_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_state", {r, r_hi, z, c, s, v, out_valid, in_ready}, 14'b1);
        foreach (vec[i]) begin
            drive(vec[i].ext, vec[i].arit, vec[i].op, vec[i].a, vec[i].b);
            chk($sformatf("vec%0d", i), {r, r_hi, z, c, s, v, out_valid},
                {vec[i].r, 4'b0000, vec[i].z, vec[i].c, vec[i].s, vec[i].v, 1'b1});
        end
        for (int ar = 0; ar < 2; ar++)
            for (int o = 0; o < 4; o++)
                for (int xa = 0; xa < 16; xa++)
                    for (int xb = 0; xb < 16; xb++) begin
                        drive(1'b0, ar[0], o[1:0], xa[3:0], xb[3:0]);
                        e = model(ar[0], o, xa, xb);
                        chk($sformatf("sweep ar%0d op%0d a%0h b%0h", ar, o, xa, xb),
                            {r, z, c, s, v, out_valid, r_hi}, {e, 1'b1, 4'b0000});
                    end
        idle();
        drive(1'b1, 1'b0, 2'd0, 4'b1111, 4'b1111);
        in_valid = 1'b0;
        chk("mul_ready_after_accept", {in_ready, out_valid}, 2'b00);
        k = 0;
        while (!out_valid && k < 10) begin
            @(posedge clk);
            #1;
            k++;
            if (!out_valid) chk("mul_busy_ready", in_ready, 0);
        end
        chk("mul_latency", k, 4);
        chk("mul_result", {r, r_hi, z, c, s, v, in_ready}, {4'b0001, 4'b1110, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1});
        idle();
        chk("mul_hold", {r, r_hi, c, out_valid}, {4'b0001, 4'b1110, 1'b1, 1'b0});
        drive(1'b0, 1'b1, 2'd0, 4'b1111, 4'b0001);
        chk("adc_chain_add", {r, r_hi, z, c, out_valid}, {4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1});
        drive(1'b1, 1'b0, 2'd1, 4'b0000, 4'b0000);
        chk("adc_chain_adc", {r, z, c, out_valid}, {4'b0001, 1'b0, 1'b0, 1'b1});
        drive(1'b1, 1'b0, 2'd0, 4'b1111, 4'b1111);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_mul_reset", {r, r_hi, z, c, s, v, out_valid, in_ready}, 14'b0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (out_valid) pulses++;
        end
        chk("no_pulse_after_abort", pulses, 0);
        drive(1'b0, 1'b1, 2'd0, 4'b0010, 4'b0011);
        chk("add_after_abort", {r, r_hi, z, c, out_valid}, {4'b0101, 4'b0000, 1'b0, 1'b0, 1'b1});
        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
